rename_unit: RTL
================

// Module: rename_unit
// PURPOSE
// - Parametrised register-rename stage between decode and dispatch; successor to the fixed 32-entry rename block.
// - Maps architectural rs1/rs2/rd to physical registers through a speculative RAT and allocates a fresh physical rd from a bitmap free list.
// - Adds a busy table (source-ready bits, woken by the CDB), a committed RAT for precise flush recovery, and a ready/valid stall when no register is free.
// PARAMETERS
// - NUM_ARCH_REGS  32  architectural registers; reg 0 is hardwired zero.
// - NUM_PHYS_REGS  64  physical registers; must be > NUM_ARCH_REGS.
// - AREG_W         $clog2(NUM_ARCH_REGS)  architectural index width (derived).
// - PREG_W         $clog2(NUM_PHYS_REGS)  physical index width (derived).
// PORTS
// - clk_i              in   1       clock, rising edge
// - reset_ni           in   1       asynchronous, active-low reset
// - inst_valid_i       in   1       decoded instruction present
// - rs1_addr_i         in   AREG_W  arch source 1
// - rs2_addr_i         in   AREG_W  arch source 2
// - rd_addr_i          in   AREG_W  arch destination
// - rd_we_i            in   1       instruction writes rd
// - rename_ready_o     out  1       stage can accept the instruction this cycle
// - prs1_addr_o        out  PREG_W  physical source 1
// - prs2_addr_o        out  PREG_W  physical source 2
// - prs1_ready_o       out  1       source 1 value available
// - prs2_ready_o       out  1       source 2 value available
// - prd_addr_o         out  PREG_W  newly allocated physical rd
// - prd_old_addr_o     out  PREG_W  previous mapping of rd (sent to ROB, freed at commit)
// - free_count_o       out  PREG_W+1  number of free physical registers
// - cdb_en_i           in   1       CDB broadcast valid
// - cdb_preg_addr_i    in   PREG_W  physical register being written back
// - commit_en_i        in   1       ROB retires an instruction that wrote rd
// - commit_rd_i        in   AREG_W  arch rd of the retiring instruction
// - commit_prd_i       in   PREG_W  its physical rd
// - commit_old_prd_i   in   PREG_W  its prd_old; returned to the free list
// - flush_i            in   1       mispredict / exception recovery
// BEHAVIOUR
// - Reset (async, reset_ni = 0):
//   - sRAT[i] = cRAT[i] = i.
//   - Free bitmap holds pregs NUM_ARCH_REGS..NUM_PHYS_REGS-1; free_count_o = 32 at default parameters.
//   - Busy table cleared, so all ready outputs read 1.
// - Lookups are combinational from current state; all state updates occur at the rising edge.
//   - A new mapping is visible to the next instruction one cycle later.
// - Handshake:
//   - Fire = inst_valid_i & rename_ready_o & !flush_i.
//   - rename_ready_o = (free_count_o != 0) | !rd_we_i | (rd_addr_i == 0).
//   - Inputs must be held while valid & !ready.
// - Sources:
//   - prsN_addr_o = sRAT[rsN] before this instruction's rd update, so rs == rd reads the old mapping.
//   - prsN_ready_o = !busy[prsN] | (cdb_en_i & cdb_preg_addr_i == prsN).
//   - Arch reg 0 always maps to preg 0 and reads ready.
// - Allocation on fire with rd_we_i & rd_addr_i != 0:
//   - prd_addr_o = lowest-index free preg; prd_old_addr_o = sRAT[rd].
//   - Next edge: sRAT[rd] <= prd, clear its free bit, set busy[prd].
// - Fire without allocation: prd_addr_o = prd_old_addr_o = 0; RAT and free list unchanged.
// - No fire: prd_addr_o = 0; no state changes from the rename path.
// - CDB: clears busy[cdb_preg_addr_i] at the edge. Same-cycle allocation of that preg (cannot occur legally) leaves the set winning.
// - Commit: cRAT[commit_rd_i] <= commit_prd_i; set free bit of commit_old_prd_i.
//   - A freed register becomes allocatable next cycle, not the same cycle.
//   - Commit with rd 0 is ignored.
// - Flush (priority over rename):
//   - The same-cycle commit is applied first.
//   - sRAT <= post-commit cRAT.
//   - Free bitmap <= complement of the set of pregs mapped in the post-commit cRAT (preg 0 never free).
//   - Busy table cleared.
//   - The instruction presented that cycle is dropped.
// - Reset mid-operation discards all speculative and committed state to the reset values.
// - free_count_o is a popcount of the free bitmap (registered, updated each edge); at default parameters it never exceeds 32.
// STRUCTURE
// - Package rename_pkg: NUM_ARCH_REGS / NUM_PHYS_REGS defaults, areg_t / preg_t typedefs, rat_t array type.
// - One sub-module, rename_free_list:
//   - Bitmap, lowest-index priority encoder, alloc/free ports, rebuild-from-mask input for flush, count output.
// - Top level holds sRAT, cRAT, busy table, handshake and bypass logic.
// TESTING
// - Reset, then rename rd=5 (rs1=5): prs1=5, prd=32, prd_old=5, prs1_ready=1; next cycle rs1=5 -> prs1=32, prs1_ready=0.
// - With busy p32, cdb_en_i=1 on p32 and rs1=5 in the same cycle -> prs1_ready=1 (bypass); it stays 1 afterwards.
// - 32 back-to-back renames -> prd 32..63, free_count 0, rename_ready_o=0 for a writing instruction; a store (rd_we_i=0) still fires.
// - At free_count 0, commit with old_prd=5 -> next cycle ready=1, prd=5.
// - Rename rd=3 -> p32 and rd=4 -> p33, commit only rd=3, then flush:
//   - sRAT[3]=32, sRAT[4]=4.
//   - p33 free again; p3 free (old mapping committed out).
//   - Busy table clear.
// - rd=0 with rd_we_i=1 -> prd=0, no allocation, free_count unchanged; reset_ni low mid-stream -> identity map and free_count 32.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared defaults and types for the register-rename stage.
// Defaults use a DEF_ prefix so they do not collide with the module parameters that take them as defaults.
package rename_pkg;
   localparam int DEF_ARCH_REGS = 32;
   localparam int DEF_PHYS_REGS = 64;
   localparam int DEF_AREG_W    = $clog2(DEF_ARCH_REGS);
   localparam int DEF_PREG_W    = $clog2(DEF_PHYS_REGS);

   typedef logic [DEF_AREG_W-1:0] areg_t;
   typedef logic [DEF_PREG_W-1:0] preg_t;
   typedef preg_t rat_t [DEF_ARCH_REGS];
endpackage

// File: rtl/rename_free_list.sv
// Bitmap free list of physical registers: lowest-index allocation, commit-time free,
// whole-map rebuild on flush, and a registered popcount.
module rename_free_list import rename_pkg::*; #(
   parameter int NUM_PHYS  = DEF_PHYS_REGS,
   parameter int NUM_RESVD = DEF_ARCH_REGS,
   parameter int PW        = $clog2(NUM_PHYS)
) (
   input  logic                clk_i,
   input  logic                reset_ni,
   input  logic                alloc_en,
   input  logic                free_en,
   input  logic [PW-1:0]       free_idx,
   input  logic                rebuild_en,
   input  logic [NUM_PHYS-1:0] rebuild_mask,
   output logic [PW-1:0]       alloc_idx,
   output logic [PW:0]         count
);
   logic [NUM_PHYS-1:0] free_q, free_d;
   logic [PW:0]         count_d;

   always_comb begin
      alloc_idx = '0;
      for (int i = NUM_PHYS-1; i >= 0; i--)
         if (free_q[i]) alloc_idx = PW'(i);
   end

   // A register freed this cycle only lands in free_q at the edge, so it is never
   // handed out in the same cycle it is returned.
   always_comb begin
      free_d = free_q;
      if (rebuild_en) free_d = rebuild_mask;
      else begin
         if (alloc_en) free_d[alloc_idx] = 1'b0;
         if (free_en)  free_d[free_idx]  = 1'b1;
      end
      free_d[0] = 1'b0;
      count_d = '0;
      for (int i = 0; i < NUM_PHYS; i++)
         count_d = count_d + (PW+1)'(free_d[i]);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < NUM_PHYS; i++)
            free_q[i] <= (i >= NUM_RESVD);
         count <= (PW+1)'(NUM_PHYS - NUM_RESVD);
      end else begin
         free_q <= free_d;
         count  <= count_d;
      end
   end
endmodule

// File: rtl/rename_unit.sv
// Register rename stage: speculative/committed RATs, busy table with CDB bypass,
// free-list allocation with ready/valid stall, and flush recovery from the committed RAT.
module rename_unit import rename_pkg::*; #(
   parameter int NUM_ARCH_REGS = DEF_ARCH_REGS,
   parameter int NUM_PHYS_REGS = DEF_PHYS_REGS,
   parameter int AREG_W        = $clog2(NUM_ARCH_REGS),
   parameter int PREG_W        = $clog2(NUM_PHYS_REGS)
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              inst_valid_i,
   input  logic [AREG_W-1:0] rs1_addr_i,
   input  logic [AREG_W-1:0] rs2_addr_i,
   input  logic [AREG_W-1:0] rd_addr_i,
   input  logic              rd_we_i,
   output logic              rename_ready_o,
   output logic [PREG_W-1:0] prs1_addr_o,
   output logic [PREG_W-1:0] prs2_addr_o,
   output logic              prs1_ready_o,
   output logic              prs2_ready_o,
   output logic [PREG_W-1:0] prd_addr_o,
   output logic [PREG_W-1:0] prd_old_addr_o,
   output logic [PREG_W:0]   free_count_o,
   input  logic              cdb_en_i,
   input  logic [PREG_W-1:0] cdb_preg_addr_i,
   input  logic              commit_en_i,
   input  logic [AREG_W-1:0] commit_rd_i,
   input  logic [PREG_W-1:0] commit_prd_i,
   input  logic [PREG_W-1:0] commit_old_prd_i,
   input  logic              flush_i
);
   logic [PREG_W-1:0]        srat_q    [NUM_ARCH_REGS];
   logic [PREG_W-1:0]        crat_q    [NUM_ARCH_REGS];
   logic [PREG_W-1:0]        crat_post [NUM_ARCH_REGS];
   logic [NUM_PHYS_REGS-1:0] busy_q, busy_d, mapped;
   logic [PREG_W-1:0]        alloc_idx;
   logic                     alloc_req, fire, do_alloc, commit_fire;

   assign alloc_req      = rd_we_i & (rd_addr_i != '0);
   assign rename_ready_o = (free_count_o != '0) | !alloc_req;
   assign fire           = inst_valid_i & rename_ready_o & !flush_i;
   assign do_alloc       = fire & alloc_req;
   assign commit_fire    = commit_en_i & (commit_rd_i != '0);

   // Sources read the pre-update sRAT, so rs == rd sees the old mapping.
   assign prs1_addr_o  = (rs1_addr_i == '0) ? '0 : srat_q[rs1_addr_i];
   assign prs2_addr_o  = (rs2_addr_i == '0) ? '0 : srat_q[rs2_addr_i];
   assign prs1_ready_o = (rs1_addr_i == '0) | !busy_q[prs1_addr_o]
                         | (cdb_en_i & (cdb_preg_addr_i == prs1_addr_o));
   assign prs2_ready_o = (rs2_addr_i == '0) | !busy_q[prs2_addr_o]
                         | (cdb_en_i & (cdb_preg_addr_i == prs2_addr_o));

   assign prd_addr_o     = do_alloc ? alloc_idx : '0;
   assign prd_old_addr_o = do_alloc ? srat_q[rd_addr_i] : '0;

   // Same-cycle commit is folded in before flush recovery copies the committed map.
   always_comb begin
      crat_post = crat_q;
      if (commit_fire) crat_post[commit_rd_i] = commit_prd_i;
      mapped = '0;
      for (int i = 0; i < NUM_ARCH_REGS; i++)
         mapped[crat_post[i]] = 1'b1;
      mapped[0] = 1'b1;
   end

   always_comb begin
      busy_d = busy_q;
      if (cdb_en_i) busy_d[cdb_preg_addr_i] = 1'b0;
      if (do_alloc) busy_d[alloc_idx]       = 1'b1;
      if (flush_i)  busy_d                  = '0;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            srat_q[i] <= PREG_W'(i);
            crat_q[i] <= PREG_W'(i);
         end
         busy_q <= '0;
      end else begin
         crat_q <= crat_post;
         busy_q <= busy_d;
         if (flush_i)       srat_q <= crat_post;
         else if (do_alloc) srat_q[rd_addr_i] <= alloc_idx;
      end
   end

   rename_free_list #(
      .NUM_PHYS  (NUM_PHYS_REGS),
      .NUM_RESVD (NUM_ARCH_REGS),
      .PW        (PREG_W)
   ) u_free_list (
      .clk_i        (clk_i),
      .reset_ni     (reset_ni),
      .alloc_en     (do_alloc),
      .free_en      (commit_fire & !flush_i),
      .free_idx     (commit_old_prd_i),
      .rebuild_en   (flush_i),
      .rebuild_mask (~mapped),
      .alloc_idx    (alloc_idx),
      .count        (free_count_o)
   );
endmodule
